// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8E1 serial transmitter.
// Frame is start, 8 data bits LSB first, even parity, stop.
module uart_tx #(
    parameter int clk_per_bit = 868,
    parameter int fifo_depth  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_data_valid,
    input  logic [7:0] i_data_byte,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int cnt_w = $clog2(fifo_depth + 1);
    localparam logic [15:0] bit_last = 16'(clk_per_bit - 1);
    localparam logic [cnt_w-1:0] depth_c = cnt_w'(fifo_depth);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [7:0]       mem [fifo_depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;
    logic             push;
    logic             pop;
    logic             empty;
    logic [7:0]       head;

    state_t     state;
    state_t     state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [2:0]  idx;
    logic [2:0]  idx_n;
    logic [7:0]  shift;
    logic [7:0]  shift_n;
    logic        par;
    logic        par_n;
    logic        tx_n;
    logic        done_n;
    logic        bit_end;

    assign o_ready = count < depth_c;
    assign empty   = count == '0;
    assign push    = i_data_valid && o_ready;
    assign head    = mem[rd_ptr];
    assign bit_end = cnt == bit_last;
    assign o_busy  = state != IDLE;

    // Storage needs no reset; count and pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= i_data_byte;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_w'(wr_ptr + 1'b1);
            end
            if (pop) begin
                rd_ptr <= ptr_w'(rd_ptr + 1'b1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            par    <= 1'b0;
            o_tx   <= 1'b1;
            o_done <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shift  <= shift_n;
            par    <= par_n;
            o_tx   <= tx_n;
            o_done <= done_n;
        end
    end

    // Line level follows the current state, so o_tx lags state by one edge.
    always_comb begin
        state_n = state;
        cnt_n   = bit_end ? 16'd0 : cnt + 16'd1;
        idx_n   = idx;
        shift_n = shift;
        par_n   = par;
        tx_n    = 1'b1;
        done_n  = 1'b0;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    par_n   = ^head;
                    state_n = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (bit_end) begin
                    idx_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                tx_n = shift[0];
                if (bit_end) begin
                    shift_n = shift >> 1;
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = PARITY;
                    end
                end
            end
            PARITY: begin
                tx_n = par;
                if (bit_end) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_n = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        par_n   = ^head;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, timing, FIFO and reset.
// A line monitor decodes frames at mid-bit into a queue.
module tb_uart_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       i_data_valid = 1'b0;
    logic [7:0] i_data_byte = 8'h00;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [10:0] bits;
        int          start;
        int          dones;
        int          done_idx;
        int          busy_low;
        logic        busy_end;
    } frame_t;

    frame_t frames[$];

    uart_tx #(
        .clk_per_bit(16),
        .fifo_depth (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .i_data_valid(i_data_valid),
        .i_data_byte (i_data_byte),
        .o_ready     (o_ready),
        .o_tx        (o_tx),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        frame_t f;
        forever begin
            @(negedge clock);
            if (!reset && o_tx === 1'b0) begin
                f.start    = cyc;
                f.bits     = '0;
                f.dones    = 0;
                f.done_idx = -1;
                f.busy_low = 0;
                f.busy_end = 1'b0;
                for (int i = 0; i < 176; i++) begin
                    if (i > 0) @(negedge clock);
                    if (i % 16 == 7) f.bits[i/16] = o_tx;
                    if (o_done) begin
                        f.dones++;
                        f.done_idx = i;
                    end
                    if (i < 175 && !o_busy) f.busy_low++;
                    if (i == 175) f.busy_end = o_busy;
                end
                frames.push_back(f);
            end
        end
    end

    task automatic put(input logic [7:0] b);
        i_data_valid = 1'b1;
        i_data_byte  = b;
        @(negedge clock);
        i_data_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int limit);
        int w;
        w = 0;
        while (frames.size() < n && w < limit) begin
            @(negedge clock);
            w++;
        end
        check("frame_count", frames.size(), n);
    endtask

    task automatic check_frame(input string tag, input frame_t f,
                               input logic [7:0] b, input logic p);
        check(tag, f.bits, {1'b1, p, b, 1'b0});
        check({tag, "_dones"}, f.dones, 1);
        check({tag, "_done_at"}, f.done_idx, 175);
        check({tag, "_busy"}, f.busy_low, 0);
    endtask

    initial begin
        int a;
        int rel;
        int late;
        int prev;
        int w;
        frame_t f;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        logic [7:0] t4_d[6] = '{8'h11, 8'h07, 8'h80, 8'hFE, 8'h3C, 8'h99};
        logic       t4_p[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] t6_d[5] = '{8'hC3, 8'h5A, 8'h0F, 8'h01, 8'h70};
        logic       t6_p[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        repeat (3) @(negedge clock);
        check("rst_tx", o_tx, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_ready", o_ready, 1);
        reset = 1'b0;

        // single byte from idle
        put(8'h55);
        a = cyc;
        check("ready_one", o_ready, 1);
        wait_frames(1, 400);
        if (frames.size() > 0) begin
            f = frames.pop_front();
            check("lat_55", f.start, a + 2);
            check_frame("f55", f, 8'h55, 1'b0);
            check("busy_end_55", f.busy_end, 0);
        end
        check("idle_busy", o_busy, 0);
        check("idle_tx", o_tx, 1);

        // two bytes back to back
        i_data_valid = 1'b1;
        i_data_byte  = 8'h01;
        @(negedge clock);
        a = cyc;
        i_data_byte = 8'hA5;
        @(negedge clock);
        i_data_valid = 1'b0;
        wait_frames(2, 800);
        if (frames.size() > 1) begin
            f = frames.pop_front();
            check("lat_01", f.start, a + 2);
            check_frame("f01", f, 8'h01, 1'b1);
            check("busy_end_01", f.busy_end, 1);
            prev = f.start;
            f = frames.pop_front();
            check("period_a5", f.start - prev, 176);
            check_frame("fa5", f, 8'hA5, 1'b0);
            check("busy_end_a5", f.busy_end, 0);
        end

        // six writes on consecutive cycles, sixth dropped
        for (int i = 0; i < 6; i++) begin
            i_data_valid = 1'b1;
            i_data_byte  = t4_d[i];
            @(negedge clock);
            if (i == 3) check("ready_4th", o_ready, 1);
            if (i == 4) check("full_5th", o_ready, 0);
        end
        i_data_valid = 1'b0;
        wait_frames(5, 1200);
        repeat (300) @(negedge clock);
        check("no_6th", frames.size(), 5);
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            if (frames.size() > 0) begin
                f = frames.pop_front();
                check_frame($sformatf("t4_%0d", i), f, t4_d[i], t4_p[i]);
                if (i > 0) check("period_t4", f.start - prev, 176);
                prev = f.start;
            end
        end

        // reset mid-frame with bytes queued
        put(8'hFF);
        a = cyc;
        put(8'h12);
        put(8'h34);
        while (cyc < a + 52) @(negedge clock);
        check("busy_pre_rst", o_busy, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_tx", o_tx, 1);
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_ready", o_ready, 1);
        check("rst_mid_done", o_done, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        rel = cyc;
        repeat (400) @(negedge clock);
        late = 0;
        foreach (frames[k]) if (frames[k].start > rel) late++;
        check("no_frame_after_rst", late, 0);
        check("tx_after_rst", o_tx, 1);
        frames.delete();

        // line returns high at once when reset hits the start bit
        put(8'h00);
        a = cyc;
        while (cyc < a + 5) @(negedge clock);
        check("start_low", o_tx, 0);
        #2 reset = 1'b1;
        #1;
        check("async_tx_high", o_tx, 1);
        @(negedge clock);
        reset = 1'b0;
        repeat (250) @(negedge clock);
        frames.delete();

        // push while full at the stop-bit pop
        put(t6_d[0]);
        a = cyc;
        for (int i = 1; i < 5; i++) put(t6_d[i]);
        check("full_t6", o_ready, 0);
        while (cyc < a + 176) @(negedge clock);
        check("full_pre_stop", o_ready, 0);
        i_data_valid = 1'b1;
        i_data_byte  = 8'hEE;
        @(negedge clock);
        check("ready_after_pop", o_ready, 1);
        check("done_at_pop", o_done, 1);
        i_data_valid = 1'b0;
        wait_frames(5, 1200);
        repeat (300) @(negedge clock);
        check("no_extra_t6", frames.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (frames.size() > 0) begin
                f = frames.pop_front();
                check_frame($sformatf("t6_%0d", i), f, t6_d[i], t6_p[i]);
            end
        end

        // random bytes with random gaps
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            b = 8'($urandom_range(0, 255));
            i_data_valid = 1'b1;
            i_data_byte  = b;
            w = 0;
            while (!o_ready && w < 2000) begin
                @(negedge clock);
                w++;
            end
            check("accept_rand", o_ready, 1);
            @(negedge clock);
            i_data_valid = 1'b0;
            exp_q.push_back(b);
        end
        wait_frames(20, 5000);
        for (int k = 0; k < 20; k++) begin
            if (frames.size() > 0 && exp_q.size() > 0) begin
                f = frames.pop_front();
                b = exp_q.pop_front();
                check_frame($sformatf("rnd_%0d", k), f, b,
                            ($countones(b) % 2) == 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
